// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage; DMEM_BYTE_EN adds a per-lane store-enable port (be).
// Latency: request at edge E0, access at E0+WAIT_CYCLES+1, one-cycle ready pulse the cycle after.
// Backpressure: stall holds the pipeline while a request is pending or waiting; misaligned requests are rejected.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        misalign
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            accept, reject, access;
    logic            lat_we;
    logic [IW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;
`ifdef DMEM_BYTE_EN
    logic [3:0]      lat_be;
`endif
    logic [31:0]     mem [DEPTH];

    logic            aligned;
    logic [IW-1:0]   req_idx;
    logic            unused_addr_bits;

    assign aligned = (addr[1:0] == 2'b00);
    assign req_idx = addr[IW+1:2];
    // Bits above the index field alias onto the same words.
    assign unused_addr_bits = ^addr[31:IW+2];

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (aligned) begin
                        stall     = 1'b1;
                        accept    = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata    <= 32'd0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            misalign <= reject;
            if (accept) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !lat_we) begin
                rdata <= mem[lat_idx];
            end
        end
    end

    // Request capture and array write; a store aborted by reset never reaches the array.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lat_we    <= we;
            lat_idx   <= req_idx;
            lat_wdata <= wdata;
`ifdef DMEM_BYTE_EN
            lat_be    <= be;
`endif
        end
        if (access && lat_we && !rst) begin
`ifdef DMEM_BYTE_EN
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
`else
            mem[lat_idx] <= lat_wdata;
`endif
        end
    end

endmodule
